parity_arbiter: RTL

PARITY_ARBITER -- requirements
Module: parity_arbiter

---
 rtl/parity_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/parity_arbiter.sv
// Four-requester round-robin arbiter that returns the XOR parity of the granted word
// LATENCY edges after accept. Define PARITY_ARB_STATS_EN to add a done_count output.
module parity_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic               rsp_parity,
  output logic               busy
`ifdef PARITY_ARB_STATS_EN
  ,
  output logic [15:0]        done_count
`endif
);

  localparam int unsigned NREQ    = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    acc_id_q;
  logic               acc_par_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_parity_q;
  logic               busy_q;

  logic [NREQ-1:0]    grant_c;
  logic [ID_W-1:0]    sel_id_c;
  logic [ID_W-1:0]    idx_c;
  logic               found_c;
  logic               sel_par_c;
  logic [WIDTH-1:0]   word_c [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign word_c[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last served requester.
  always_comb begin
    grant_c  = '0;
    sel_id_c = '0;
    idx_c    = '0;
    found_c  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_c = ptr_q + ID_W'(k);
      if (!found_c && req_valid[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        sel_id_c       = idx_c;
        found_c        = 1'b1;
      end
    end
  end

  assign sel_par_c = ^word_c[sel_id_c];

  // Grant is only offered when idle and out of reset.
  assign req_ready  = (reset_n && state_q == IDLE) ? grant_c : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_parity = rsp_parity_q;
  assign busy       = busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(3);
      acc_id_q     <= '0;
      acc_par_q    <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_parity_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_c) begin
            acc_id_q  <= sel_id_c;
            acc_par_q <= sel_par_c;
            busy_q    <= 1'b1;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_id_q     <= sel_id_c;
              rsp_parity_q <= sel_par_c;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= acc_id_q;
            rsp_parity_q <= acc_par_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // Result is held until the consumer takes it; the served id becomes the new pointer.
          if (rsp_ready) begin
            state_q      <= IDLE;
            ptr_q        <= rsp_id_q;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_parity_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PARITY_ARB_STATS_EN
  logic [STATS_W-1:0] done_q;

  // Saturating count of completed response handshakes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
    end else if (state_q == RESP && rsp_ready && done_q != {STATS_W{1'b1}}) begin
      done_q <= done_q + STATS_W'(1);
    end
  end

  assign done_count = done_q;
`endif

endmodule
